// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: mode encodings and parameter check.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package usr_pkg;

    // Operation select; codes 6 and 7 are reserved and behave as HOLD
    typedef enum logic [2:0] {
        USR_HOLD = 3'b000,
        USR_SHR  = 3'b001,
        USR_SHL  = 3'b010,
        USR_LOAD = 3'b011,
        USR_ROTR = 3'b100,
        USR_ROTL = 3'b101
    } usr_mode_e;

    localparam int USR_MODE_W = 3;

    // A word must split into a whole number of steps, and at least two shifts per word
    function automatic bit usr_cfg_ok(input int width, input int step);
        return (width >= 2) && (step >= 1) && (step < width) && ((width % step) == 0);
    endfunction

endpackage

// File: rtl/usr_step_counter.sv
// Modulo-NSHIFT shift counter with a registered one-cycle wrap pulse.
// Latency: cnt/done update on the edge that carries clr/inc.
// Backpressure: none; caller gates inc/clr with its own enable.
module usr_step_counter #(
    parameter  int NSHIFT = 8,
    localparam int CW     = $clog2(NSHIFT + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] cnt,
    output logic          done
);

    localparam logic [CW-1:0] CNT_LAST = CW'(NSHIFT - 1);

    // Clear dominates increment; done is only raised on the wrapping increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            done <= 1'b0;
        end else if (clr) begin
            cnt  <= '0;
            done <= 1'b0;
        end else if (inc) begin
            if (cnt == CNT_LAST) begin
                cnt  <= '0;
                done <= 1'b1;
            end else begin
                cnt  <= cnt + 1'b1;
                done <= 1'b0;
            end
        end else begin
            done <= 1'b0;
        end
    end

endmodule

// File: rtl/universal_shift_register.sv
// Universal shift register: load, shift right/left by STEP, rotate (USR_ROTATE_EN), hold.
// Latency: q_out and serial outs reflect an operation right after its clock edge.
// Backpressure: none; en=0 freezes all state and drops done.
module universal_shift_register
    import usr_pkg::*;
#(
    parameter  int WIDTH  = 8,
    parameter  int STEP   = 1,
    localparam int NSHIFT = WIDTH / STEP,
    localparam int CW     = $clog2(NSHIFT + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [USR_MODE_W-1:0] mode,
    input  logic [STEP-1:0]       sin_r,
    input  logic [STEP-1:0]       sin_l,
    input  logic [WIDTH-1:0]      pdata_in,
    output logic [WIDTH-1:0]      q_out,
    output logic [STEP-1:0]       so_r,
    output logic [STEP-1:0]       so_l,
    output logic [CW-1:0]         shift_cnt,
    output logic                  done
);

    if (!usr_cfg_ok(WIDTH, STEP)) begin : g_bad_cfg
        $error("universal_shift_register: need WIDTH>=2, STEP<WIDTH, WIDTH%%STEP==0");
    end

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_nxt;
    logic             shift_op;
    logic             load_op;

    // Next-state select; serial inputs only reach q on their own shift direction
    always_comb begin
        q_nxt    = q;
        shift_op = 1'b0;
        load_op  = 1'b0;
        case (mode)
            USR_SHR: begin
                q_nxt    = {sin_r, q[WIDTH-1:STEP]};
                shift_op = 1'b1;
            end
            USR_SHL: begin
                q_nxt    = {q[WIDTH-STEP-1:0], sin_l};
                shift_op = 1'b1;
            end
            USR_LOAD: begin
                q_nxt   = pdata_in;
                load_op = 1'b1;
            end
`ifdef USR_ROTATE_EN
            USR_ROTR: begin
                q_nxt    = {q[STEP-1:0], q[WIDTH-1:STEP]};
                shift_op = 1'b1;
            end
            USR_ROTL: begin
                q_nxt    = {q[WIDTH-STEP-1:0], q[WIDTH-1:WIDTH-STEP]};
                shift_op = 1'b1;
            end
`endif
            default: begin
                q_nxt = q;
            end
        endcase
    end

    // Data register, frozen while en is low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            q <= q_nxt;
        end
    end

    usr_step_counter #(
        .NSHIFT (NSHIFT)
    ) u_step_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (en & load_op),
        .inc   (en & shift_op),
        .cnt   (shift_cnt),
        .done  (done)
    );

    assign q_out = q;
    assign so_r  = q[STEP-1:0];
    assign so_l  = q[WIDTH-1:WIDTH-STEP];

endmodule

// File: tb/tb_universal_shift_register.sv
// Bench for universal_shift_register: 8x1 instance (model + scoreboard) and 16x4 instance.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_universal_shift_register;

    logic clk;
    logic rst_n;

    // 8-bit, STEP=1 instance
    logic       a_en;
    logic [2:0] a_mode;
    logic       a_sin_r, a_sin_l;
    logic [7:0] a_pdata;
    logic [7:0] a_q;
    logic       a_so_r, a_so_l;
    logic [3:0] a_cnt;
    logic       a_done;

    // 16-bit, STEP=4 instance
    logic        b_en;
    logic [2:0]  b_mode;
    logic [3:0]  b_sin_r, b_sin_l;
    logic [15:0] b_pdata;
    logic [15:0] b_q;
    logic [3:0]  b_so_r, b_so_l;
    logic [2:0]  b_cnt;
    logic        b_done;

    universal_shift_register #(.WIDTH(8), .STEP(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .en(a_en), .mode(a_mode),
        .sin_r(a_sin_r), .sin_l(a_sin_l), .pdata_in(a_pdata),
        .q_out(a_q), .so_r(a_so_r), .so_l(a_so_l),
        .shift_cnt(a_cnt), .done(a_done)
    );

    universal_shift_register #(.WIDTH(16), .STEP(4)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .en(b_en), .mode(b_mode),
        .sin_r(b_sin_r), .sin_l(b_sin_l), .pdata_in(b_pdata),
        .q_out(b_q), .so_r(b_so_r), .so_l(b_so_l),
        .shift_cnt(b_cnt), .done(b_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [15:0] q;
        logic [3:0]  cnt;
        logic        done;
    } exp_t;

    exp_t sb[$];

    int n_assert = 0;
    int n_fail   = 0;

    // Reference state of the 8-bit instance
    logic [7:0] m_q;
    logic [3:0] m_cnt;
    logic       m_done;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one operation on instance A, predict its result, then compare after the edge
    task automatic step_a(input logic en, input logic [2:0] mode, input logic sin_r,
                          input logic sin_l, input logic [7:0] pd, input string tag);
        exp_t       e;
        exp_t       got;
        logic [7:0] nq;
        logic       sh;
        a_en = en; a_mode = mode; a_sin_r = sin_r; a_sin_l = sin_l; a_pdata = pd;
        nq = m_q;
        sh = 1'b0;
        case (mode)
            3'b001: begin nq = {sin_r, m_q[7:1]}; sh = 1'b1; end
            3'b010: begin nq = {m_q[6:0], sin_l}; sh = 1'b1; end
`ifdef USR_ROTATE_EN
            3'b100: begin nq = {m_q[0], m_q[7:1]}; sh = 1'b1; end
            3'b101: begin nq = {m_q[6:0], m_q[7]}; sh = 1'b1; end
`endif
            default: nq = m_q;
        endcase
        if (!en) begin
            m_done = 1'b0;
        end else if (mode == 3'b011) begin
            m_q = pd; m_cnt = 4'd0; m_done = 1'b0;
        end else if (sh) begin
            m_q = nq;
            if (m_cnt == 4'd7) begin m_cnt = 4'd0; m_done = 1'b1; end
            else begin m_cnt = m_cnt + 4'd1; m_done = 1'b0; end
        end else begin
            m_done = 1'b0;
        end
        e.tag = tag; e.q = {8'h00, m_q}; e.cnt = m_cnt; e.done = m_done;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        check_eq({got.tag, ":q"},    32'(a_q),    32'(got.q));
        check_eq({got.tag, ":cnt"},  32'(a_cnt),  32'(got.cnt));
        check_eq({got.tag, ":done"}, 32'(a_done), 32'(got.done));
        check_eq({got.tag, ":so_r"}, 32'(a_so_r), 32'(got.q[0]));
        check_eq({got.tag, ":so_l"}, 32'(a_so_l), 32'(got.q[7]));
    endtask

    // Drive instance B with an explicitly stated expectation
    task automatic step_b(input logic [2:0] mode, input logic [3:0] sin_r, input logic [15:0] pd,
                          input logic [15:0] xq, input logic [2:0] xcnt, input logic xdone,
                          input string tag);
        exp_t e;
        exp_t got;
        b_en = 1'b1; b_mode = mode; b_sin_r = sin_r; b_sin_l = 4'h0; b_pdata = pd;
        e.tag = tag; e.q = xq; e.cnt = {1'b0, xcnt}; e.done = xdone;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        check_eq({got.tag, ":q"},    32'(b_q),    32'(got.q));
        check_eq({got.tag, ":cnt"},  32'(b_cnt),  32'(got.cnt));
        check_eq({got.tag, ":done"}, 32'(b_done), 32'(got.done));
        check_eq({got.tag, ":so_r"}, 32'(b_so_r), 32'(got.q[3:0]));
        check_eq({got.tag, ":so_l"}, 32'(b_so_l), 32'(got.q[15:12]));
    endtask

    logic [7:0] a5_bits;

    initial begin
        rst_n = 1'b0;
        a_en = 1'b0; a_mode = 3'b000; a_sin_r = 1'b0; a_sin_l = 1'b0; a_pdata = 8'h00;
        b_en = 1'b0; b_mode = 3'b000; b_sin_r = 4'h0; b_sin_l = 4'h0; b_pdata = 16'h0000;
        m_q = 8'h00; m_cnt = 4'd0; m_done = 1'b0;
        #12;
        check_eq("rst:q",    32'(a_q),    32'h0);
        check_eq("rst:cnt",  32'(a_cnt),  32'h0);
        check_eq("rst:done", 32'(a_done), 32'h0);
        check_eq("rst:bq",   32'(b_q),    32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset between edges aborts a shift in progress
        step_a(1'b1, 3'b011, 1'b0, 1'b0, 8'hFF, "t1_load");
        for (int i = 0; i < 3; i++) step_a(1'b1, 3'b001, 1'b0, 1'b0, 8'h00, "t1_shr");
        rst_n = 1'b0;
        #1;
        check_eq("t1_async:q",    32'(a_q),    32'h00);
        check_eq("t1_async:cnt",  32'(a_cnt),  32'h0);
        check_eq("t1_async:done", 32'(a_done), 32'h0);
        m_q = 8'h00; m_cnt = 4'd0; m_done = 1'b0;
        #1 rst_n = 1'b1;

        // Serialise 0xA5 LSB first; done only after the 8th shift
        a5_bits = 8'hA5;
        step_a(1'b1, 3'b011, 1'b0, 1'b0, 8'hA5, "t2_load");
        for (int i = 0; i < 8; i++) begin
            check_eq("t2_so_r_pre", 32'(a_so_r), 32'(a5_bits[i]));
            step_a(1'b1, 3'b001, 1'b0, 1'b0, 8'h00, "t2_shr");
            check_eq("t2_done_lit", 32'(a_done), (i == 7) ? 32'h1 : 32'h0);
        end
        check_eq("t2_q_lit", 32'(a_q), 32'h00);
        step_a(1'b1, 3'b000, 1'b0, 1'b0, 8'h00, "t2_hold");

        // Left shift in ones
        step_a(1'b1, 3'b011, 1'b0, 1'b0, 8'h00, "t3_load");
        for (int i = 0; i < 3; i++) step_a(1'b1, 3'b010, 1'b0, 1'b1, 8'h00, "t3_shl");
        check_eq("t3_q_lit",    32'(a_q),    32'h07);
        check_eq("t3_so_l_lit", 32'(a_so_l), 32'h0);
        check_eq("t3_cnt_lit",  32'(a_cnt),  32'h3);

        // Enable low freezes everything
        step_a(1'b1, 3'b011, 1'b0, 1'b0, 8'h78, "t4_load");
        step_a(1'b1, 3'b001, 1'b0, 1'b0, 8'h00, "t4_shr");
        for (int i = 0; i < 5; i++) step_a(1'b0, 3'b001, 1'b1, 1'b1, 8'hFF, "t4_frozen");
        check_eq("t4_q_lit",   32'(a_q),   32'h3C);
        check_eq("t4_cnt_lit", 32'(a_cnt), 32'h1);

        // Rotate (or HOLD when rotate is compiled out)
        step_a(1'b1, 3'b011, 1'b0, 1'b0, 8'h81, "t5_load");
        step_a(1'b1, 3'b100, 1'b0, 1'b0, 8'h00, "t5_rotr");
`ifdef USR_ROTATE_EN
        check_eq("t5_q_lit",   32'(a_q),   32'hC0);
        check_eq("t5_cnt_lit", 32'(a_cnt), 32'h1);
`else
        check_eq("t5_q_lit",   32'(a_q),   32'h81);
        check_eq("t5_cnt_lit", 32'(a_cnt), 32'h0);
`endif
        step_a(1'b1, 3'b101, 1'b0, 1'b0, 8'h00, "t5_rotl");

        // LOAD on what would be the wrapping cycle wins
        step_a(1'b1, 3'b011, 1'b0, 1'b0, 8'h5A, "wrap_load");
        for (int i = 0; i < 7; i++) step_a(1'b1, 3'b010, 1'b0, 1'b1, 8'h00, "wrap_shl");
        step_a(1'b1, 3'b011, 1'b0, 1'b0, 8'hC3, "wrap_vs_load");
        step_a(1'b1, 3'b110, 1'b1, 1'b1, 8'h00, "rsvd6");
        step_a(1'b1, 3'b111, 1'b1, 1'b1, 8'h00, "rsvd7");

        // Mixed traffic against the model
        for (int i = 0; i < 150; i++) begin
            step_a(($urandom_range(0, 7) != 0), 3'($urandom_range(0, 7)),
                   1'($urandom), 1'($urandom), 8'($urandom), "rand");
        end
        a_en = 1'b0;

        // Wide nibble-step instance
        step_b(3'b011, 4'h0, 16'h1234, 16'h1234, 3'd0, 1'b0, "t6_load");
        step_b(3'b001, 4'hF, 16'h0000, 16'hF123, 3'd1, 1'b0, "t6_shr1");
        step_b(3'b001, 4'hF, 16'h0000, 16'hFF12, 3'd2, 1'b0, "t6_shr2");
        step_b(3'b001, 4'hF, 16'h0000, 16'hFFF1, 3'd3, 1'b0, "t6_shr3");
        step_b(3'b001, 4'hF, 16'h0000, 16'hFFFF, 3'd0, 1'b1, "t6_shr4");
        step_b(3'b000, 4'h0, 16'h0000, 16'hFFFF, 3'd0, 1'b0, "t6_hold");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
